// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - start/result handshake between control unit and MULT/DIV sequencer
interface muldiv_sequencer_if #(parameter int WIDTH = 32);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             hilo_we;
  logic             divby0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    input  busy, done, hilo_we, divby0, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, hilo_we, divby0, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - signed shift-add MULT / restoring DIV sequencer owning HI/LO
// Optional MULDIV_FAST_ZERO_EN: zero operands complete in one cycle.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  muldiv_sequencer_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MULT = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic               op_q, neg_q, sign_a_q, divz_q;
  logic               done_q, hilo_we_q, divby0_q;
  logic [WIDTH-1:0]   hi_q, lo_q;

  logic               accept, b_zero, fast_zero, last_iter;
  logic [WIDTH-1:0]   mag_a, mag_b, addend, rem_fix, quo_fix;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] mul_next, div_next, result;

  assign accept    = bus.start && (state == S_IDLE) && !done_q;
  assign mag_a     = bus.a[WIDTH-1] ? -bus.a : bus.a;
  assign mag_b     = bus.b[WIDTH-1] ? -bus.b : bus.b;
  assign b_zero    = (bus.b == '0);
  assign last_iter = (cnt == CW'(WIDTH - 1));

`ifdef MULDIV_FAST_ZERO_EN
  logic a_zero;
  assign a_zero    = (bus.a == '0);
  assign fast_zero = bus.op ? (a_zero && !b_zero) : (a_zero || b_zero);
`else
  assign fast_zero = 1'b0;
`endif

  // MULT: acc = {partial product, remaining multiplier bits}, shifted right each step
  assign addend   = acc[0] ? opnd : '0;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // DIV: acc = {remainder, dividend/quotient}, shifted left; trial subtract restores on borrow
  assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
  assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                      : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  assign rem_fix = sign_a_q ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  assign quo_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign result  = (!op_q && neg_q) ? -acc : acc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      acc       <= '0;
      opnd      <= '0;
      op_q      <= 1'b0;
      neg_q     <= 1'b0;
      sign_a_q  <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
      hilo_we_q <= 1'b0;
      divby0_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      done_q    <= (state == S_DONE);
      hilo_we_q <= (state == S_DONE) && !divz_q;
      divby0_q  <= (state == S_DONE) && divz_q;
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q     <= bus.op;
            neg_q    <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
            sign_a_q <= bus.a[WIDTH-1];
            divz_q   <= bus.op && b_zero;
            cnt      <= '0;
            opnd     <= bus.op ? mag_b : mag_a;
            acc      <= {{WIDTH{1'b0}}, bus.op ? mag_a : mag_b};
            if ((bus.op && b_zero) || fast_zero) begin
              acc   <= '0;
              state <= S_DONE;
            end else begin
              state <= bus.op ? S_DIV : S_MULT;
            end
          end
        end
        S_MULT: begin
          acc <= mul_next;
          cnt <= cnt + 1'b1;
          if (last_iter) state <= S_DONE;
        end
        S_DIV: begin
          acc <= div_next;
          cnt <= cnt + 1'b1;
          if (last_iter) state <= S_FIX;
        end
        S_FIX: begin
          acc   <= {rem_fix, quo_fix};
          state <= S_DONE;
        end
        S_DONE: begin
          if (!divz_q) begin
            hi_q <= result[2*WIDTH-1:WIDTH];
            lo_q <= result[WIDTH-1:0];
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy    = (state != S_IDLE) || done_q;
  assign bus.done    = done_q;
  assign bus.hilo_we = hilo_we_q;
  assign bus.divby0  = divby0_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - scoreboard bench for muldiv_sequencer
module tb_muldiv_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  muldiv_sequencer_if #(.WIDTH(32)) bus();

  muldiv_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
    logic        dz;
    int          due;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: native 64-bit signed arithmetic, truncating division
  task automatic push_exp(input logic op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb_v;
    logic [63:0] p;
    int          lat;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    e.we = 1'b1;
    e.dz = 1'b0;
    if (!op) begin
      p   = sa * sb_v;
      lat = 33;
`ifdef MULDIV_FAST_ZERO_EN
      if (a == 0 || b == 0) lat = 1;
`endif
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == 0) begin
      lat  = 1;
      e.we = 1'b0;
      e.dz = 1'b1;
      e.hi = model_hi;
      e.lo = model_lo;
    end else begin
      p    = sa % sb_v;
      e.hi = p[31:0];
      p    = sa / sb_v;
      e.lo = p[31:0];
      lat  = 34;
`ifdef MULDIV_FAST_ZERO_EN
      if (a == 0) lat = 1;
`endif
    end
    e.due    = cyc + 1 + lat;
    model_hi = e.hi;
    model_lo = e.lo;
    sb.push_back(e);
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'b0, bus.done}, 64'd0);
      end else begin
        e = sb.pop_front();
        check("done_cycle", cyc, e.due);
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("hilo_we", bus.hilo_we, e.we);
        check("divby0", bus.divby0, e.dz);
      end
    end else if (!reset) begin
      check("stray_pulse", {62'b0, bus.hilo_we, bus.divby0}, 64'd0);
    end
  end

  task automatic issue(input logic op, input logic [31:0] a, input logic [31:0] b, input int hold);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    push_exp(op, a, b);
    @(negedge clk);
    check("busy_after_start", bus.busy, 1);
    for (int i = 1; i < hold; i++) @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 0);
      sb.delete();
    end else begin
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("busy_after_done", bus.busy, 0);
    end
  endtask

  task automatic run(input logic op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b, 1);
    wait_done();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_done", bus.done, 0);
    check("reset_hi", bus.hi, 0);
    check("reset_lo", bus.lo, 0);
    check("reset_pulses", {bus.hilo_we, bus.divby0}, 0);

    run(1'b0, 32'd7, 32'hFFFF_FFFD);
    run(1'b1, 32'd100, 32'hFFFF_FFF9);
    run(1'b1, 32'hFFFF_FF9C, 32'd7);
    run(1'b1, 32'h451, 32'h20);
    run(1'b1, 32'd5, 32'd0);
    run(1'b0, 32'h8000_0000, 32'h8000_0000);
    run(1'b0, 32'h7FFF_FFFF, 32'h8000_0000);

    // Overflow divide with a second start while busy
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd3;
    bus.b     = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done();
    repeat (40) @(negedge clk);

    // Start held for several cycles is accepted once
    issue(1'b0, 32'hFFFF_FFF0, 32'd5, 3);
    wait_done();
    repeat (40) @(negedge clk);

    // Reset mid-operation discards the result
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 1'b0;
    bus.a     = 32'd9;
    bus.b     = 32'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check("midreset_busy", bus.busy, 0);
    check("midreset_hi", bus.hi, 0);
    check("midreset_lo", bus.lo, 0);
    check("midreset_done", bus.done, 0);
    repeat (40) @(negedge clk);

    run(1'b0, 32'd3, 32'd4);
    run(1'b0, 32'd0, 32'd9);
    run(1'b1, 32'd0, 32'd9);
    run(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    for (int i = 0; i < 10; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      run(1'($urandom_range(0, 1)), ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
